// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: op and state encodings,
// default operand width and the iteration-counter width helper.
package md_pkg;

  typedef enum logic [1:0] {
    MD_MULTU = 2'd0,
    MD_MULT  = 2'd1,
    MD_DIVU  = 2'd2,
    MD_DIV   = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } md_state_e;

  localparam int MD_WIDTH = 32;

  // Counter only has to hold WIDTH-1 down to 0.
  function automatic int md_cnt_w(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

  localparam int MD_CNT_W = md_cnt_w(MD_WIDTH);

endpackage

// File: rtl/md_step.sv
// Single iteration of the sequencer datapath: one shift-add step of a radix-2
// multiply, or one shift/subtract/compare step of a restoring divide.
// Multiply: acc holds the upper partial product, mq the multiplier.
// Divide:   acc holds the partial remainder, mq the dividend/quotient.
module md_step
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mq,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] mq_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  // Compute both step flavours and pick one according to the latched op.
  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no latch is inferred.
    acc_nxt = acc;
    mq_nxt  = mq;
    // Carry is kept in sum[WIDTH] and shifted back into acc.
    sum     = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    // Partial remainder is always below the divisor, so WIDTH+1 bits hold
    // the shifted value and trial[WIDTH] is a reliable borrow/sign bit.
    rem_sh  = {acc, mq[WIDTH-1]};
    trial   = rem_sh - {1'b0, opnd};
    if (is_div) begin
      if (!trial[WIDTH]) begin
        acc_nxt = trial[WIDTH-1:0];
        mq_nxt  = {mq[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = rem_sh[WIDTH-1:0];
        mq_nxt  = {mq[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nxt = sum[WIDTH:1];
      mq_nxt  = {sum[0], mq[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer with HI/LO result registers.
// Optional macro MD_SIGNED_EN: when defined, op_i[0] selects signed operation
// (abs on entry, sign correction in FIX); when undefined every op is unsigned
// and FIX is a pass-through cycle with identical latency.
module mul_div_seq
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = md_cnt_w(WIDTH);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             is_div_q;
  logic [WIDTH-1:0] acc_q, mq_q, opnd_q;
  logic [WIDTH-1:0] acc_nxt, mq_nxt;
  logic             div_by_zero;
  logic [WIDTH-1:0] a_in, b_in;
  logic [WIDTH-1:0] fix_hi, fix_lo;

  assign div_by_zero = op_i[1] && (src2_i == '0);

`ifdef MD_SIGNED_EN
  logic neg_a_q, neg_b_q;
  logic neg_a_in, neg_b_in;

  assign neg_a_in = op_i[0] & src1_i[WIDTH-1];
  assign neg_b_in = op_i[0] & src2_i[WIDTH-1];
  // abs(MIN) wraps to MIN, which read as unsigned is exactly 2^(WIDTH-1).
  assign a_in     = neg_a_in ? -src1_i : src1_i;
  assign b_in     = neg_b_in ? -src2_i : src2_i;

  // Remember operand signs for the FIX-cycle correction.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
    end else if (state_q == S_IDLE && start_i) begin
      neg_a_q <= neg_a_in;
      neg_b_q <= neg_b_in;
    end
  end

  // Sign correction: product negated on differing signs; quotient likewise,
  // remainder follows the dividend.
  always_comb begin
    fix_hi = acc_q;
    fix_lo = mq_q;
    if (is_div_q) begin
      fix_lo = (neg_a_q ^ neg_b_q) ? -mq_q : mq_q;
      fix_hi = neg_a_q ? -acc_q : acc_q;
    end else if (neg_a_q ^ neg_b_q) begin
      {fix_hi, fix_lo} = -{acc_q, mq_q};
    end
  end
`else
  logic unused_sign_sel;

  assign unused_sign_sel = op_i[0];
  assign a_in            = src1_i;
  assign b_in            = src2_i;
  assign fix_hi          = acc_q;
  assign fix_lo          = mq_q;
`endif

  md_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div_q),
    .acc     (acc_q),
    .mq      (mq_q),
    .opnd    (opnd_q),
    .acc_nxt (acc_nxt),
    .mq_nxt  (mq_nxt)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake outputs; busy covers everything but IDLE.
  always_comb begin
    state_d = state_q;
    busy_o  = 1'b1;
    done_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_d = div_by_zero ? S_DONE : S_RUN;
      end
      S_RUN:   if (cnt_q == '0) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, iteration, and HI/LO result registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      acc_q      <= '0;
      mq_q       <= '0;
      opnd_q     <= '0;
      hi_o       <= '0;
      lo_o       <= '0;
      div_zero_o <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            is_div_q   <= op_i[1];
            div_zero_o <= div_by_zero;
            if (div_by_zero) begin
              hi_o <= src1_i;
              lo_o <= '1;
            end else begin
              acc_q  <= '0;
              // Divide iterates on the dividend, multiply on the multiplier.
              mq_q   <= op_i[1] ? a_in : b_in;
              opnd_q <= op_i[1] ? b_in : a_in;
              cnt_q  <= CNT_W'(WIDTH - 1);
            end
          end
        end
        S_RUN: begin
          acc_q <= acc_nxt;
          mq_q  <= mq_nxt;
          cnt_q <= cnt_q - CNT_W'(1);
        end
        S_FIX: begin
          hi_o <= fix_hi;
          lo_o <= fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_seq.sv
// Bench for mul_div_seq: transaction-level timing/arithmetic model checked
// every cycle, plus directed vectors with literal expected values.
// Honours MD_SIGNED_EN the same way the design does.
module tb_mul_div_seq;
  import md_pkg::*;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic [1:0]   op_i;
  logic [W-1:0] src1_i, src2_i;
  logic         busy_o, done_o, div_zero_o;
  logic [W-1:0] hi_o, lo_o;

  int total = 0;
  int bad   = 0;

  mul_div_seq #(.WIDTH(W)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .op_i       (op_i),
    .src1_i     (src1_i),
    .src2_i     (src2_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .div_zero_o (div_zero_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference computed with plain 64-bit math.
  function automatic void model_result(input logic [1:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b, output logic [W-1:0] hi,
                                       output logic [W-1:0] lo, output logic dz);
    logic               sgn;
    logic signed [63:0] sa, sb, q, r, p;
`ifdef MD_SIGNED_EN
    sgn = op[0];
`else
    sgn = 1'b0;
`endif
    sa = sgn ? {{32{a[W-1]}}, a} : {32'b0, a};
    sb = sgn ? {{32{b[W-1]}}, b} : {32'b0, b};
    dz = 1'b0;
    hi = '0;
    lo = '0;
    if (op[1]) begin
      if (b == '0) begin
        dz = 1'b1;
        hi = a;
        lo = '1;
      end else begin
        q  = sa / sb;
        r  = sa % sb;
        lo = q[W-1:0];
        hi = r[W-1:0];
      end
    end else begin
      p  = sa * sb;
      hi = p[63:32];
      lo = p[W-1:0];
    end
  endfunction

  // Transaction model: cycles remaining until the op retires (0 = idle).
  int           m_cnt   = 0;
  bit           m_valid = 1'b0;
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  logic         m_dz;

  always @(posedge clk_i) begin
    logic [W-1:0] r_hi, r_lo;
    logic         r_dz;
    if (!rst_i) begin
      m_cnt   = 0;
      m_hi    = '0;
      m_lo    = '0;
      m_dz    = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_cnt == 0) begin
        if (start_i) begin
          model_result(op_i, src1_i, src2_i, r_hi, r_lo, r_dz);
          m_dz = r_dz;
          if (r_dz) begin
            m_hi  = r_hi;
            m_lo  = r_lo;
            m_cnt = 1;
          end else begin
            p_hi  = r_hi;
            p_lo  = r_lo;
            m_cnt = W + 2;
          end
        end
      end else begin
        m_cnt--;
        if (m_cnt == 1) begin
          m_hi = p_hi;
          m_lo = p_lo;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk_i) begin
    if (m_valid) begin
      check("busy", busy_o, m_cnt != 0);
      check("done", done_o, m_cnt == 1);
      check("div_zero", div_zero_o, m_dz);
      check("hi", hi_o, m_hi);
      check("lo", lo_o, m_lo);
    end
  end

  // Issue one op from an IDLE-cycle negedge; optionally poke start or reset
  // mid-run. Returns latency in cycles, or -1 if aborted by reset.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int poke_at, input int rst_at, output int lat);
    start_i = 1'b1;
    op_i    = op;
    src1_i  = a;
    src2_i  = b;
    @(negedge clk_i);
    start_i = 1'b0;
    op_i    = MD_DIV;
    src1_i  = 32'hDEAD_BEEF;
    src2_i  = 32'h0;
    lat     = 1;
    while (!done_o && lat < 100) begin
      if (lat == poke_at) begin
        start_i = 1'b1;
        op_i    = MD_DIVU;
        src1_i  = 32'd12345;
        src2_i  = 32'd0;
      end
      if (lat == rst_at) rst_i = 1'b0;
      @(negedge clk_i);
      start_i = 1'b0;
      if (!rst_i) begin
        rst_i = 1'b1;
        lat   = -1;
        return;
      end
      lat++;
    end
    if (lat >= 100) check("done_timeout", done_o, 1'b1);
    @(negedge clk_i);
  endtask

  initial begin
    int lat;
    rst_i   = 1'b0;
    start_i = 1'b0;
    op_i    = 2'd0;
    src1_i  = '0;
    src2_i  = '0;
    repeat (2) @(negedge clk_i);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_hi", hi_o, 32'h0);
    check("rst_lo", lo_o, 32'h0);
    check("rst_dz", div_zero_o, 1'b0);
    rst_i = 1'b1;
    @(negedge clk_i);

    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'h2, 0, 0, lat);
    check("multu_lat", lat, 34);
    check("multu_hi", hi_o, 32'h0000_0001);
    check("multu_lo", lo_o, 32'hFFFF_FFFE);

    run_op(MD_MULT, 32'hFFFF_FFFD, 32'h7, 0, 0, lat);
`ifdef MD_SIGNED_EN
    check("mult_hi", hi_o, 32'hFFFF_FFFF);
`else
    check("mult_hi", hi_o, 32'h0000_0006);
`endif
    check("mult_lo", lo_o, 32'hFFFF_FFEB);

    run_op(MD_DIV, 32'hFFFF_FFF9, 32'h2, 0, 0, lat);
`ifdef MD_SIGNED_EN
    check("div_lo", lo_o, 32'hFFFF_FFFD);
    check("div_hi", hi_o, 32'hFFFF_FFFF);
`else
    check("div_lo", lo_o, 32'h7FFF_FFFC);
    check("div_hi", hi_o, 32'h0000_0001);
`endif

    run_op(MD_DIVU, 32'd100, 32'd7, 0, 0, lat);
    check("divu_lo", lo_o, 32'd14);
    check("divu_hi", hi_o, 32'd2);
    check("divu_lat", lat, 34);

    run_op(MD_DIVU, 32'h1234, 32'h0, 0, 0, lat);
    check("dz_lat", lat, 1);
    check("dz_flag", div_zero_o, 1'b1);
    check("dz_lo", lo_o, 32'hFFFF_FFFF);
    check("dz_hi", hi_o, 32'h0000_1234);

    run_op(MD_MULTU, 32'd3, 32'd3, 0, 0, lat);
    check("dz_clear", div_zero_o, 1'b0);
    check("mul9_lo", lo_o, 32'd9);
    check("mul9_hi", hi_o, 32'd0);

    run_op(MD_MULTU, 32'h0001_0000, 32'h0001_0000, 10, 0, lat);
    check("poke_lat", lat, 34);
    check("poke_hi", hi_o, 32'h1);
    check("poke_lo", lo_o, 32'h0);
    check("poke_dz", div_zero_o, 1'b0);

    run_op(MD_MULTU, 32'd5, 32'd7, 0, 20, lat);
    check("abort_flag", lat, -1);
    check("abort_busy", busy_o, 1'b0);
    check("abort_hi", hi_o, 32'h0);
    check("abort_lo", lo_o, 32'h0);

    run_op(MD_DIVU, 32'd100, 32'd7, 0, 0, lat);
    check("post_rst_lat", lat, 34);
    check("post_rst_lo", lo_o, 32'd14);
    check("post_rst_hi", hi_o, 32'd2);

    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, lat);
`ifdef MD_SIGNED_EN
    check("min_lo", lo_o, 32'h8000_0000);
    check("min_hi", hi_o, 32'h0);
`else
    check("min_lo", lo_o, 32'h0);
    check("min_hi", hi_o, 32'h8000_0000);
`endif
    check("min_dz", div_zero_o, 1'b0);

    repeat (3) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
